// File: rtl/data_receive_program.sv
// Purpose : receive end of the board-to-board serial link; synchronizes dflag and
//           the data line, deserializes an LSB-first word and checks frame length.
// Latency : data_valid rises SYNC_STAGES+1 rising edges after dflag is first sampled low.
// Backpressure: none; the sender cannot be stalled, so every frame is taken as it comes.
// Ports   : Ten_MHz_input (clock), reset_n (async, active low), data_in_1_bit / dflag
//           (serial data + envelope), data_out_18_bits (last good word),
//           data_valid / frame_err (one-cycle strobes).
// Option  : define RX_ERR_COUNT_EN to add an 8-bit saturating err_count output.
module data_receive_program #(
    parameter int DATA_WIDTH  = 18,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  Ten_MHz_input,
    input  logic                  reset_n,
    input  logic                  data_in_1_bit,
    input  logic                  dflag,
    output logic [DATA_WIDTH-1:0] data_out_18_bits,
    output logic                  data_valid,
    output logic                  frame_err
`ifdef RX_ERR_COUNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        RECV     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] flag_sync_q, flag_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    // Marks when the synchronizer holds real samples rather than reset zeros, so a
    // line already high at reset release is not mistaken for a low gap.
    logic [SYNC_STAGES-1:0] prime_q, prime_d;
    logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    state_t                 state_q, state_d;

    logic s_flag, s_data, primed;

    assign s_flag = flag_sync_q[SYNC_STAGES-1];
    assign s_data = data_sync_q[SYNC_STAGES-1];
    assign primed = prime_q[SYNC_STAGES-1];

    always_comb begin
        flag_sync_d = {flag_sync_q[SYNC_STAGES-2:0], dflag};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], data_in_1_bit};
        prime_d     = {prime_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                if (primed && !s_flag) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (s_flag) begin
                    shreg_d = {s_data, shreg_q[DATA_WIDTH-1:1]};
                    cnt_d   = CW'(1);
                    state_d = RECV;
                end
            end
            RECV: begin
                if (s_flag) begin
                    if (cnt_q < FULL) begin
                        shreg_d = {s_data, shreg_q[DATA_WIDTH-1:1]};
                        cnt_d   = cnt_q + CW'(1);
                    end else begin
                        // Overrun: drop the rest of this envelope before rearming.
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_LOW;
                    end
                end else begin
                    if (cnt_q == FULL) begin
                        data_out_d = shreg_q;
                        valid_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = WAIT_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Ten_MHz_input or negedge reset_n) begin
        if (!reset_n) begin
            flag_sync_q <= '0;
            data_sync_q <= '0;
            prime_q     <= '0;
            shreg_q     <= '0;
            data_out_q  <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= WAIT_LOW;
        end else begin
            flag_sync_q <= flag_sync_d;
            data_sync_q <= data_sync_d;
            prime_q     <= prime_d;
            shreg_q     <= shreg_d;
            data_out_q  <= data_out_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            state_q     <= state_d;
        end
    end

    assign data_out_18_bits = data_out_q;
    assign data_valid       = valid_q;
    assign frame_err        = err_q;

`ifdef RX_ERR_COUNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Counts with the error strobe itself so the count and pulse appear together.
    always_comb begin
        err_count_d = err_count_q;
        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge Ten_MHz_input or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= 8'h00;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_data_receive_program.sv
`timescale 1ns/1ps
module tb_data_receive_program;

    logic        clk;
    logic        reset_n;
    logic        data_in_1_bit;
    logic        dflag;
    logic [17:0] data_out_18_bits;
    logic        data_valid;
    logic        frame_err;
`ifdef RX_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    int checks = 0;
    int passes = 0;

    // Pulse monitor, sampled 1 ns after each rising edge.
    int          valid_pulses = 0;
    int          err_pulses   = 0;
    int          both_pulses  = 0;
    logic [17:0] got[$];

    data_receive_program #(.DATA_WIDTH(18), .SYNC_STAGES(2)) dut (
        .Ten_MHz_input    (clk),
        .reset_n          (reset_n),
        .data_in_1_bit    (data_in_1_bit),
        .dflag            (dflag),
        .data_out_18_bits (data_out_18_bits),
        .data_valid       (data_valid),
        .frame_err        (frame_err)
`ifdef RX_ERR_COUNT_EN
        ,
        .err_count        (err_count)
`endif
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (data_valid) begin
            valid_pulses++;
            got.push_back(data_out_18_bits);
        end
        if (frame_err) err_pulses++;
        if (data_valid && frame_err) both_pulses++;
    end

    // Sender model: drive on falling edges, len bits of word LSB first, then drop dflag.
    task automatic send_frame(input logic [31:0] word, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            dflag         = 1'b1;
            data_in_1_bit = (i < 32) ? word[i] : 1'b0;
        end
        @(negedge clk);
        dflag         = 1'b0;
        data_in_1_bit = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; dflag = 1'b0; data_in_1_bit = 1'b0;
        #20;
        checks++; if (data_out_18_bits !== 18'h0) $display("FAIL reset_data got %h exp 00000", data_out_18_bits); else passes++;
        checks++; if (data_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", data_valid); else passes++;
        checks++; if (frame_err !== 1'b0) $display("FAIL reset_err got %b exp 0", frame_err); else passes++;
`ifdef RX_ERR_COUNT_EN
        checks++; if (err_count !== 8'h00) $display("FAIL reset_errcnt got %h exp 00", err_count); else passes++;
`endif
        idle(2);
        reset_n = 1'b1;
        idle(5);
    endtask

    task automatic test_good;
        int e0;
        logic exp_v;
        e0 = err_pulses;
        send_frame(32'h2D5A3, 18);
        // dflag just dropped at a falling edge; valid must appear after the 3rd rising edge only.
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #2;
            exp_v = (k == 3);
            checks++; if (data_valid !== exp_v) $display("FAIL good_latency edge%0d got %b exp %b", k, data_valid, exp_v); else passes++;
        end
        checks++; if (data_out_18_bits !== 18'h2D5A3) $display("FAIL good_data got %h exp 2d5a3", data_out_18_bits); else passes++;
        idle(3);
        checks++; if (err_pulses != e0) $display("FAIL good_noerr got %0d exp %0d", err_pulses, e0); else passes++;
    endtask

    task automatic test_short;
        int v0, e0;
        send_frame(32'h00FFF, 18);
        idle(5);
        checks++; if (data_out_18_bits !== 18'h00FFF) $display("FAIL short_pre got %h exp 00fff", data_out_18_bits); else passes++;
        v0 = valid_pulses; e0 = err_pulses;
        send_frame(32'h3FFFF, 10);
        idle(6);
        checks++; if (err_pulses != e0 + 1) $display("FAIL short_err got %0d exp %0d", err_pulses, e0 + 1); else passes++;
        checks++; if (valid_pulses != v0) $display("FAIL short_novalid got %0d exp %0d", valid_pulses, v0); else passes++;
        checks++; if (data_out_18_bits !== 18'h00FFF) $display("FAIL short_hold got %h exp 00fff", data_out_18_bits); else passes++;
`ifdef RX_ERR_COUNT_EN
        checks++; if (err_count !== 8'd1) $display("FAIL short_errcnt got %0d exp 1", err_count); else passes++;
`endif
    endtask

    task automatic test_long;
        int v0, e0;
        v0 = valid_pulses; e0 = err_pulses;
        send_frame(32'h0A5A5, 20);
        idle(6);
        checks++; if (err_pulses != e0 + 1) $display("FAIL long_err got %0d exp %0d", err_pulses, e0 + 1); else passes++;
        checks++; if (valid_pulses != v0) $display("FAIL long_novalid got %0d exp %0d", valid_pulses, v0); else passes++;
`ifdef RX_ERR_COUNT_EN
        checks++; if (err_count !== 8'd2) $display("FAIL long_errcnt got %0d exp 2", err_count); else passes++;
`endif
        send_frame(32'h3FFFF, 18);
        idle(5);
        checks++; if (data_out_18_bits !== 18'h3FFFF) $display("FAIL long_next_data got %h exp 3ffff", data_out_18_bits); else passes++;
        checks++; if (valid_pulses != v0 + 1) $display("FAIL long_next_valid got %0d exp %0d", valid_pulses, v0 + 1); else passes++;
    endtask

    task automatic test_back_to_back;
        int v0, base;
        v0 = valid_pulses; base = got.size();
        send_frame(32'h15555, 18);
        send_frame(32'h2AAAA, 18);   // one falling-edge low gap between envelopes
        idle(6);
        checks++; if (valid_pulses != v0 + 2) $display("FAIL b2b_count got %0d exp %0d", valid_pulses, v0 + 2); else passes++;
        if (got.size() >= base + 2) begin
            checks++; if (got[base] !== 18'h15555) $display("FAIL b2b_first got %h exp 15555", got[base]); else passes++;
            checks++; if (got[base+1] !== 18'h2AAAA) $display("FAIL b2b_second got %h exp 2aaaa", got[base+1]); else passes++;
        end else begin
            checks++; $display("FAIL b2b_words got %0d words exp 2", got.size() - base);
        end
    endtask

    task automatic test_reset_mid;
        int v0, e0;
        logic [17:0] w;
        w = 18'h3C3C3;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            dflag = 1'b1; data_in_1_bit = w[i];
            if (i == 7) reset_n = 1'b0;
            if (i == 9) begin
                reset_n = 1'b1;
                v0 = valid_pulses; e0 = err_pulses;
                checks++; if (data_out_18_bits !== 18'h0) $display("FAIL rstmid_clear got %h exp 00000", data_out_18_bits); else passes++;
            end
        end
        @(negedge clk);
        dflag = 1'b0; data_in_1_bit = 1'b0;
        idle(6);
        checks++; if (valid_pulses != v0) $display("FAIL rstmid_novalid got %0d exp %0d", valid_pulses, v0); else passes++;
        checks++; if (err_pulses != e0) $display("FAIL rstmid_noerr got %0d exp %0d", err_pulses, e0); else passes++;
        send_frame(32'h00001, 18);
        idle(5);
        checks++; if (data_out_18_bits !== 18'h00001) $display("FAIL rstmid_next got %h exp 00001", data_out_18_bits); else passes++;
        checks++; if (valid_pulses != v0 + 1) $display("FAIL rstmid_next_valid got %0d exp %0d", valid_pulses, v0 + 1); else passes++;
    endtask

    task automatic test_stuck;
        int v0, e0;
        @(negedge clk);
        reset_n = 1'b0; dflag = 1'b1; data_in_1_bit = 1'b1;
        idle(2);
        reset_n = 1'b1;
        v0 = valid_pulses; e0 = err_pulses;
        idle(100);
        checks++; if (valid_pulses != v0) $display("FAIL stuck_novalid got %0d exp %0d", valid_pulses, v0); else passes++;
        checks++; if (err_pulses != e0) $display("FAIL stuck_noerr got %0d exp %0d", err_pulses, e0); else passes++;
        dflag = 1'b0; data_in_1_bit = 1'b0;
        idle(5);
        send_frame(32'h12345, 18);
        idle(5);
        checks++; if (data_out_18_bits !== 18'h12345) $display("FAIL stuck_next got %h exp 12345", data_out_18_bits); else passes++;
        checks++; if (err_pulses != e0) $display("FAIL stuck_next_noerr got %0d exp %0d", err_pulses, e0); else passes++;
    endtask

    initial begin
        test_reset();
        test_good();
        test_short();
        test_long();
        test_back_to_back();
        test_reset_mid();
        test_stuck();
        checks++; if (both_pulses != 0) $display("FAIL exclusive_pulses got %0d exp 0", both_pulses); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_receive_program.md
Name: data_receive_program

Overview:
- Receiving end of the board-to-board serial link.
- The sending DE2 asserts dflag and shifts out an 18-bit switch word, LSB first, one bit per 10 MHz clock. It changes data on the falling edge, so this block samples on the rising edge.
- This block synchronizes dflag and the data line, deserializes the word and checks the frame length. It then presents the word in parallel, for example to LEDs or 7-segment drivers on the receiving board, with a one-cycle valid strobe.
- The link runs from a forwarded 10 MHz clock, so the bit rate equals the receiver clock rate.

Parameters:
- DATA_WIDTH, 18: bits per frame; this is also the exact number of cycles dflag must be high.
- SYNC_STAGES, 2: flip-flop stages on dflag and the data line. Minimum 2.

Ports:
- Ten_MHz_input, input, 1: 10 MHz clock; all logic uses its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- data_in_1_bit, input, 1: serial data from the sender, LSB first.
- dflag, input, 1: frame envelope from the sender; high for exactly DATA_WIDTH bit times.
- data_out_18_bits, output, DATA_WIDTH: last good received word; holds until the next good frame.
- data_valid, output, 1: one-cycle pulse when data_out_18_bits updates.
- frame_err, output, 1: one-cycle pulse on a short or long frame.

Behaviour:
- Reset (asynchronous): data_out_18_bits=0, data_valid=0, frame_err=0, shift register=0, bit count=0, synchronizer flops=0, state=WAIT_LOW.
- Synchronizers: dflag and data_in_1_bit each pass through SYNC_STAGES flops with equal delay, giving s_flag and s_data. All decisions below use s_flag and s_data only.
- Shift register: shreg <= {s_data, shreg[DATA_WIDTH-1:1]}. After DATA_WIDTH shifts, the first bit received sits at bit 0.
- Bit count: width $clog2(DATA_WIDTH+1); it never wraps.

State machine:
- WAIT_LOW:
  - Entered after reset and after an overrun.
  - Stay while s_flag=1; go to IDLE when s_flag=0.
  - A line stuck high after reset never produces a frame.
- IDLE:
  - If s_flag=1: shift in s_data, set count=1, go to RECV.
  - Otherwise hold.
- RECV, s_flag=1 and count<DATA_WIDTH: shift, count+1.
- RECV, s_flag=1 and count==DATA_WIDTH (overrun): pulse frame_err next cycle, count=0, go to WAIT_LOW, no data_valid.
- RECV, s_flag=0 and count==DATA_WIDTH (good frame): next cycle data_out_18_bits<=shreg and data_valid=1 for one cycle; count=0; go to IDLE.
- RECV, s_flag=0 and count!=DATA_WIDTH (short frame): next cycle frame_err=1 for one cycle; data_out_18_bits unchanged; count=0; go to IDLE.

Latency and back-to-back frames:
- data_valid rises SYNC_STAGES+1 rising edges after the first rising edge at which raw dflag samples 0.
- Back-to-back frames with a 1-cycle dflag-low gap must both be received.
- A frame start (s_flag=1) in the same cycle as the end-of-frame decision cannot occur, because the decision is made on s_flag=0.

Simultaneous events:
- data_valid and frame_err are never high in the same cycle.
- reset_n low mid-frame: immediate clear as above; the remainder of that frame is ignored via WAIT_LOW.

Optional Feature:
- Macro: RX_ERR_COUNT_EN.
- When defined: adds output err_count, 8 bits, reset 0. It increments on every frame_err pulse, saturates at 8'hFF, and is cleared only by reset_n.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Good frame: send 18'h2D5A3 LSB first (dflag high 18 cycles) -> data_out_18_bits=18'h2D5A3, data_valid high exactly 1 cycle, 3 edges after dflag falls; frame_err=0.
2. Short frame: dflag high 10 cycles after a prior good 18'h00FFF -> frame_err one pulse; data_out_18_bits stays 18'h00FFF; no data_valid; with RX_ERR_COUNT_EN, err_count=1.
3. Long frame: dflag high 20 cycles -> frame_err pulse after the 19th synchronized high; no data_valid; a following good frame 18'h3FFFF is received correctly.
4. Back-to-back: 18'h15555, 1-cycle gap, 18'h2AAAA -> two data_valid pulses, outputs 18'h15555 then 18'h2AAAA.
5. Reset mid-frame: reset_n low at bit 7, released while dflag is still high -> outputs 0, no valid or error for that frame; the next frame 18'h00001 is received.
6. Stuck line: dflag held high through reset release for 100 cycles -> no pulses. Then dflag low 5 cycles and good frame 18'h12345 -> data_out_18_bits=18'h12345.
